// File: rtl/env_rate_gen_if.sv
// Slot-strobe/result bundle between the register-file side and env_rate_gen.
// ENV_RATE_FREEZE_EN adds the freeze input.
interface env_rate_gen_if #(
  parameter int NUM_BANKS    = 2,
  parameter int OPS_PER_BANK = 18,
  parameter int OVF_WIDTH    = 3
);
  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int OP_W   = (OPS_PER_BANK > 1) ? $clog2(OPS_PER_BANK) : 1;

  logic                 sample_clk_en;
  logic [BANK_W-1:0]    bank_num;
  logic [OP_W-1:0]      op_num;
  logic                 ksr;
  logic                 nts;
  logic [9:0]           fnum;
  logic [2:0]           block;
  logic [3:0]           requested_rate_p0;
  logic                 key_on_p0;
`ifdef ENV_RATE_FREEZE_EN
  logic                 freeze;
`endif
  logic                 clear_busy;
  logic                 ovf_valid_p2;
  logic [OVF_WIDTH-1:0] rate_counter_overflow_p2;

  modport master (
`ifdef ENV_RATE_FREEZE_EN
    output freeze,
`endif
    output sample_clk_en, bank_num, op_num, ksr, nts, fnum, block,
    output requested_rate_p0, key_on_p0,
    input  clear_busy, ovf_valid_p2, rate_counter_overflow_p2
  );

  modport slave (
`ifdef ENV_RATE_FREEZE_EN
    input  freeze,
`endif
    input  sample_clk_en, bank_num, op_num, ksr, nts, fnum, block,
    input  requested_rate_p0, key_on_p0,
    output clear_busy, ovf_valid_p2, rate_counter_overflow_p2
  );
endinterface

// File: rtl/env_rate_gen.sv
// Per-slot envelope rate counter: key-scaled effective rate, phase counter RAM, overflow count at p2.
// Optional ENV_RATE_FREEZE_EN: freeze input holds all counters and zeroes the overflow output.
module env_rate_gen #(
  parameter int NUM_BANKS     = 2,
  parameter int OPS_PER_BANK  = 18,
  parameter int COUNTER_WIDTH = 15,
  parameter int RATE_MAX      = 60,
  parameter int OVF_WIDTH     = 3
) (
  input  logic         clk,
  input  logic         reset,
  env_rate_gen_if.slave bus
);
  localparam int NSLOTS    = NUM_BANKS * OPS_PER_BANK;
  localparam int ADDR_W    = (NSLOTS > 1) ? $clog2(NSLOTS) : 1;
  localparam int INC_W     = 18;
  localparam int SUM_W     = ((COUNTER_WIDTH > INC_W) ? COUNTER_WIDTH : INC_W) + 1;
  localparam int RAW_OVF_W = SUM_W - COUNTER_WIDTH;
  localparam int OVF_MAX   = (1 << OVF_WIDTH) - 1;

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  function automatic logic [5:0] clamp_rate(input logic [6:0] r);
    if (r > 7'(RATE_MAX)) clamp_rate = 6'(RATE_MAX);
    else                  clamp_rate = r[5:0];
  endfunction

  function automatic logic [OVF_WIDTH-1:0] sat_ovf(input logic [RAW_OVF_W-1:0] v);
    if (32'(v) > 32'(OVF_MAX)) sat_ovf = '1;
    else                       sat_ovf = OVF_WIDTH'(v);
  endfunction

  logic [COUNTER_WIDTH-1:0] cnt_mem [2**ADDR_W];

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
  logic                clear_busy_q, clear_busy_d;

  logic [3:0]          kval_p0;
  logic [6:0]          rate_sum_p0;
  logic [ADDR_W-1:0]   addr_p0;
  logic                freeze_p0;

  logic                     vld_p1_q, vld_p1_d;
  logic [ADDR_W-1:0]        addr_p1_q, addr_p1_d;
  logic [5:0]               eff_p1_q, eff_p1_d;
  logic                     key_on_p1_q, key_on_p1_d;
  logic                     hold_p1_q, hold_p1_d;
  logic                     freeze_p1_q, freeze_p1_d;
  logic [COUNTER_WIDTH-1:0] cnt_p1_q, cnt_p1_d;

  logic [INC_W-1:0]         inc_p1;
  logic [SUM_W-1:0]         sum_p1;
  logic                     wr_p1;
  logic [COUNTER_WIDTH-1:0] wdata_p1;

  logic                     vld_p2_q, vld_p2_d;
  logic [OVF_WIDTH-1:0]     ovf_p2_q, ovf_p2_d;

  logic                     mem_we;
  logic [ADDR_W-1:0]        mem_waddr;
  logic [COUNTER_WIDTH-1:0] mem_wdata;

  logic unused_fnum;
  assign unused_fnum = ^bus.fnum[7:0];

`ifdef ENV_RATE_FREEZE_EN
  assign freeze_p0 = bus.freeze;
`else
  assign freeze_p0 = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    if (state_q == S_CLEAR) begin
      if (clr_addr_q == ADDR_W'(NSLOTS - 1)) state_d = S_RUN;
      else                                   clr_addr_d = clr_addr_q + 1'b1;
    end
    clear_busy_d = (state_d == S_CLEAR);
  end

  // ---- p0: slot address, key scaling, effective rate, counter read ----
  always_comb begin
    kval_p0 = {bus.block, bus.nts ? bus.fnum[8] : bus.fnum[9]};
    if (!bus.ksr) kval_p0 = kval_p0 >> 2;
    rate_sum_p0 = {1'b0, bus.requested_rate_p0, 2'b00} + {3'b000, kval_p0};
    addr_p0     = ADDR_W'(bus.bank_num) * ADDR_W'(OPS_PER_BANK) + ADDR_W'(bus.op_num);

    vld_p1_d    = bus.sample_clk_en && (state_q == S_RUN);
    addr_p1_d   = addr_p0;
    eff_p1_d    = clamp_rate(rate_sum_p0);
    key_on_p1_d = bus.key_on_p0;
    hold_p1_d   = (bus.requested_rate_p0 == 4'd0);
    freeze_p1_d = freeze_p0;
    // the p1 slot commits on this same edge, so a re-read of it takes the fresh value
    if (wr_p1 && (addr_p1_q == addr_p0)) cnt_p1_d = wdata_p1;
    else                                 cnt_p1_d = cnt_mem[addr_p0];
  end

  // ---- p1: increment, overflow, write-back value ----
  always_comb begin
    inc_p1   = INC_W'({1'b1, eff_p1_q[1:0]}) << eff_p1_q[5:2];
    sum_p1   = SUM_W'(cnt_p1_q) + SUM_W'(inc_p1);
    wr_p1    = vld_p1_q && !freeze_p1_q && (key_on_p1_q || !hold_p1_q);
    wdata_p1 = key_on_p1_q ? '0 : sum_p1[COUNTER_WIDTH-1:0];

    vld_p2_d = vld_p1_q;
    if (vld_p1_q && !freeze_p1_q && !key_on_p1_q && !hold_p1_q)
      ovf_p2_d = sat_ovf(sum_p1[SUM_W-1:COUNTER_WIDTH]);
    else
      ovf_p2_d = '0;

    mem_we    = !reset && ((state_q == S_CLEAR) || wr_p1);
    mem_waddr = (state_q == S_CLEAR) ? clr_addr_q : addr_p1_q;
    mem_wdata = (state_q == S_CLEAR) ? '0 : wdata_p1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_CLEAR;
      clr_addr_q   <= '0;
      clear_busy_q <= 1'b1;
      vld_p1_q     <= 1'b0;
      vld_p2_q     <= 1'b0;
      ovf_p2_q     <= '0;
    end else begin
      state_q      <= state_d;
      clr_addr_q   <= clr_addr_d;
      clear_busy_q <= clear_busy_d;
      vld_p1_q     <= vld_p1_d;
      vld_p2_q     <= vld_p2_d;
      ovf_p2_q     <= ovf_p2_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_p1_q   <= addr_p1_d;
    eff_p1_q    <= eff_p1_d;
    key_on_p1_q <= key_on_p1_d;
    hold_p1_q   <= hold_p1_d;
    freeze_p1_q <= freeze_p1_d;
    cnt_p1_q    <= cnt_p1_d;
  end

  // ---- p2: counter write-back, registered result ----
  always_ff @(posedge clk) begin
    if (mem_we) cnt_mem[mem_waddr] <= mem_wdata;
  end

  assign bus.clear_busy               = clear_busy_q;
  assign bus.ovf_valid_p2             = vld_p2_q;
  assign bus.rate_counter_overflow_p2 = ovf_p2_q;
endmodule

// File: tb/tb_env_rate_gen.sv
// Scoreboard bench for env_rate_gen: stimulus pushes hand-computed overflow values, a monitor pops on ovf_valid_p2.
module tb_env_rate_gen;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  env_rate_gen_if bus ();
  env_rate_gen dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    int    exp;
    string tag;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  exp_t mon_e;
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (bus.ovf_valid_p2 === 1'b1) begin
        if (bus.clear_busy === 1'b1) chk("valid_in_clear", 1, 0);
        if (sb_q.size() == 0) chk("unexpected_valid", 1, 0);
        else begin
          mon_e = sb_q.pop_front();
          chk(mon_e.tag, int'(bus.rate_counter_overflow_p2), mon_e.exp);
        end
      end else if (bus.rate_counter_overflow_p2 != 0) begin
        chk("ovf_nonvalid", int'(bus.rate_counter_overflow_p2), 0);
      end
    end
  end

  task automatic visit(input int bk, input int op, input int req, input int ks, input int nt,
                       input int fn, input int blk, input int ko, input int ex, input string tag);
    exp_t e;
    @(posedge clk); #1;
    bus.sample_clk_en     = 1'b1;
    bus.bank_num          = 1'(bk);
    bus.op_num            = 5'(op);
    bus.requested_rate_p0 = 4'(req);
    bus.ksr               = 1'(ks);
    bus.nts               = 1'(nt);
    bus.fnum              = 10'(fn);
    bus.block             = 3'(blk);
    bus.key_on_p0         = 1'(ko);
    e.exp = ex;
    e.tag = tag;
    sb_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.sample_clk_en = 1'b0;
      bus.key_on_p0     = 1'b0;
    end
  endtask

  // eff=51 -> inc=28672: from a zero counter the two visits give 0 then 1
  task automatic probe(input int bk, input int op, input string tag);
    visit(bk, op, 12, 1, 0, 10'h200, 1, 0, 0, tag);
    visit(bk, op, 12, 1, 0, 10'h200, 1, 0, 1, tag);
    idle(1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    bus.sample_clk_en = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    sb_q.delete();
    chk("rst_valid", int'(bus.ovf_valid_p2), 0);
    chk("rst_ovf", int'(bus.rate_counter_overflow_p2), 0);
    chk("rst_busy", int'(bus.clear_busy), 1);
  endtask

  task automatic wait_clear(input string tag);
    int n = 0;
    while (bus.clear_busy === 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk(tag, n, 36);
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sb_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    bus.sample_clk_en = 1'b0;
    bus.bank_num = '0; bus.op_num = '0; bus.ksr = 1'b0; bus.nts = 1'b0;
    bus.fnum = '0; bus.block = '0; bus.requested_rate_p0 = '0; bus.key_on_p0 = 1'b0;
`ifdef ENV_RATE_FREEZE_EN
    bus.freeze = 1'b0;
`endif

    // sweep length, then prove the sweep clears a dirtied slot
    do_reset();
    wait_clear("clear_len_1");
    visit(1, 17, 12, 1, 0, 10'h200, 1, 0, 0, "dirty_1_17");
    idle(2);
    drain();
    do_reset();
    wait_clear("clear_len_2");
    probe(1, 17, "sweep_1_17");
    probe(0, 9, "sweep_0_9");

    // eff=60: inc=2^17, overflow 4 every visit, counter stays 0
    for (int i = 0; i < 5; i++) visit(0, 0, 15, 0, 0, 0, 0, 0, 4, "t2_eff60");
    idle(1);
    probe(0, 0, "t2_cnt_zero");

    // eff=4: inc=8, overflow only on visit 4096 (back-to-back, same slot)
    for (int i = 0; i < 4096; i++) visit(1, 5, 1, 0, 0, 0, 0, 0, (i == 4095) ? 1 : 0, "t3_rate4");
    visit(1, 5, 1, 0, 0, 0, 0, 0, 0, "t3_after");
    idle(2);

    // key scaling: kval=15 -> 75 clamped to 60
    visit(0, 1, 15, 1, 0, 10'h200, 7, 0, 4, "t4_clamp");
    // nts=1 picks fnum[8]: kval=7, eff=47, inc=14336
    for (int i = 0; i < 5; i++)
      visit(0, 2, 10, 1, 1, 10'h100, 3, 0, (i == 2 || i == 4) ? 1 : 0, "t4_ksr1");
    // ksr=0: kval=1, eff=41, inc=5120
    for (int i = 0; i < 7; i++)
      visit(0, 6, 10, 0, 1, 10'h100, 3, 0, (i == 6) ? 1 : 0, "t4_ksr0");
    idle(2);

    // hold at req=0 and key-on clear, visits spaced so reads come from the RAM
    for (int i = 0; i < 10; i++) begin visit(1, 8, 1, 0, 0, 0, 0, 0, 0, "t5_adv"); idle(1); end
    for (int i = 0; i < 100; i++) begin visit(1, 8, 0, 0, 0, 0, 0, 0, 0, "t5_hold"); idle(1); end
    for (int i = 0; i < 4086; i++) begin
      visit(1, 8, 1, 0, 0, 0, 0, 0, (i == 4085) ? 1 : 0, "t5_held80");
      idle(1);
    end
    for (int i = 0; i < 10; i++) begin visit(1, 8, 1, 0, 0, 0, 0, 0, 0, "t5_readv"); idle(1); end
    visit(1, 8, 15, 0, 0, 0, 0, 1, 0, "t5_keyon");
    idle(1);
    for (int i = 0; i < 4096; i++) begin
      visit(1, 8, 1, 0, 0, 0, 0, 0, (i == 4095) ? 1 : 0, "t5_after_keyon");
      idle(1);
    end
    drain();

`ifdef ENV_RATE_FREEZE_EN
    visit(0, 10, 12, 0, 0, 0, 0, 0, 0, "frz_pre");
    idle(1);
    bus.freeze = 1'b1;
    for (int i = 0; i < 50; i++) visit(0, 10, 12, 0, 0, 0, 0, 0, 0, "frz_on");
    idle(1);
    bus.freeze = 1'b0;
    visit(0, 10, 12, 0, 0, 0, 0, 0, 1, "frz_resume");
    idle(2);
    drain();
`endif

    // reset with results in flight, then again mid-sweep at address 20
    visit(0, 3, 15, 0, 0, 0, 0, 0, 4, "t6_inflight");
    visit(0, 3, 15, 0, 0, 0, 0, 0, 4, "t6_inflight");
    do_reset();
    repeat (20) begin @(posedge clk); #1; end
    chk("t6_busy_mid", int'(bus.clear_busy), 1);
    do_reset();
    wait_clear("clear_len_mid");
    probe(0, 2, "t6_sweep_0_2");
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
